perf_counter_unit: RTL and testbench

- Parametrised performance-monitor block for the pipelined CPU, and the successor to the single free-running 64-bit cycle counter with its every-1000-cycles sample register.
- Provides one cycle counter (channel 0) and NUM_EVT event counters (channels 1..NUM_EVT), fed by pipeline pulses: retire, hazard stall, IF/ID flush, taken branch.
- Periodically snapshots all channels into shadow registers, and exposes live and snapshot values through a registered read-select port for the display/debug path.

---
 rtl/perf_counter_unit_pkg.sv | 15 +
 rtl/perf_counter_unit_if.sv | 29 ++
 rtl/perf_counter_unit_cnt_cell.sv | 54 +++++
 rtl/perf_counter_unit.sv | 84 ++++++++
 tb/tb_perf_counter_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/perf_counter_unit_pkg.sv
// Shared constants for the performance-monitor block: event channel indices and default sizing.
package perf_pkg;

  localparam int EVT_RETIRE = 0;
  localparam int EVT_STALL  = 1;
  localparam int EVT_FLUSH  = 2;
  localparam int EVT_BRANCH = 3;

  localparam int CH_CYCLE = 0;

  localparam int DEF_NUM_EVT     = 4;
  localparam int DEF_CNT_W       = 64;
  localparam int DEF_SNAP_PERIOD = 1000;

endpackage

// File: rtl/perf_counter_unit_if.sv
// Control, event and read-back signals of the performance-monitor block.
interface perf_counter_unit_if
  import perf_pkg::*;
#(
  parameter int NUM_EVT = DEF_NUM_EVT,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               en;
  logic               freeze;
  logic               clear;
  logic [NUM_EVT-1:0] evt;
  logic [3:0]         rd_sel;
  logic [CNT_W-1:0]   rd_data;
  logic [CNT_W-1:0]   snap_data;
  logic               snap_valid;
  logic [NUM_EVT:0]   overflow;

  modport master (
    output en, freeze, clear, evt, rd_sel,
    input  rd_data, snap_data, snap_valid, overflow
  );

  modport slave (
    input  en, freeze, clear, evt, rd_sel,
    output rd_data, snap_data, snap_valid, overflow
  );

endinterface

// File: rtl/perf_counter_unit_cnt_cell.sv
// One counter channel with shadow register and sticky overflow flag.
// Define PERF_SATURATE_EN to saturate at all-ones instead of wrapping.
module perf_cnt_cell #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);

  logic [CNT_W-1:0] count_next;
  logic             ovf_next;

  always_comb begin
    count_next = count;
    ovf_next   = ovf;
    if (clr) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (inc) begin
      if (&count) begin
        ovf_next = 1'b1;
`ifdef PERF_SATURATE_EN
        count_next = count;
`else
        count_next = '0;
`endif
      end else begin
        count_next = count + CNT_W'(1);
      end
    end
  end

  // The shadow captures the post-increment value so a snapshot includes its own edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      count <= count_next;
      ovf   <= ovf_next;
      if (snap) begin
        shadow <= count_next;
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance monitor: cycle counter plus NUM_EVT event counters, periodic snapshots and
// a registered read port. Saturating mode is selected with PERF_SATURATE_EN in the cell.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_EVT     = DEF_NUM_EVT,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SNAP_PERIOD = DEF_SNAP_PERIOD
) (
  input logic                clk,
  input logic                rst,
  perf_counter_unit_if.slave bus
);

  localparam int PW = $clog2(SNAP_PERIOD);

  logic             act;
  logic             period_last;
  logic             snap;
  logic [PW-1:0]    p;
  logic [NUM_EVT:0] inc;
  logic [NUM_EVT:0] ovf;
  logic [CNT_W-1:0] counts  [NUM_EVT+1];
  logic [CNT_W-1:0] shadows [NUM_EVT+1];
  logic [CNT_W-1:0] rd_live;
  logic [CNT_W-1:0] rd_snap;

  assign act         = bus.en & ~bus.freeze & ~bus.clear;
  assign period_last = (p == PW'(SNAP_PERIOD - 1));
  assign snap        = act & period_last;
  assign bus.overflow = ovf;

  always_comb begin
    inc           = '0;
    inc[CH_CYCLE] = act;
    for (int k = 1; k <= NUM_EVT; k++) begin
      inc[k] = act & bus.evt[k-1];
    end
  end

  for (genvar k = 0; k <= NUM_EVT; k++) begin : g_ch
    perf_cnt_cell #(.CNT_W(CNT_W)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc[k]),
      .clr    (bus.clear),
      .snap   (snap),
      .count  (counts[k]),
      .shadow (shadows[k]),
      .ovf    (ovf[k])
    );
  end

  // Selects beyond the last channel read back as zero.
  always_comb begin
    rd_live = '0;
    rd_snap = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (bus.rd_sel == 4'(k)) begin
        rd_live = counts[k];
        rd_snap = shadows[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p              <= '0;
      bus.snap_valid <= 1'b0;
      bus.rd_data    <= '0;
      bus.snap_data  <= '0;
    end else begin
      if (bus.clear) begin
        p <= '0;
      end else if (act) begin
        p <= period_last ? '0 : p + PW'(1);
      end
      bus.snap_valid <= snap;
      bus.rd_data    <= rd_live;
      bus.snap_data  <= rd_snap;
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: a default 64-bit instance and a 16-bit instance for wrap/saturate.
module tb_perf_counter_unit;
  import perf_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  perf_counter_unit_if #(.NUM_EVT(4), .CNT_W(64)) bus_a ();
  perf_counter_unit_if #(.NUM_EVT(4), .CNT_W(16)) bus_b ();

  perf_counter_unit #(.NUM_EVT(4), .CNT_W(64), .SNAP_PERIOD(1000)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  perf_counter_unit #(.NUM_EVT(4), .CNT_W(16), .SNAP_PERIOD(1000)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic en, input logic freeze, input logic clear,
                               input logic [3:0] evt, input logic [3:0] rd_sel);
    bus_a.en     = en;
    bus_a.freeze = freeze;
    bus_a.clear  = clear;
    bus_a.evt    = evt;
    bus_a.rd_sel = rd_sel;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [3:0] stall_pulse;
  logic [3:0] retire_pulse;
  logic [15:0] b_wrap_read;
  logic [15:0] b_next_read;

  initial begin
    stall_pulse  = 4'b0;
    retire_pulse = 4'b0;
    stall_pulse[EVT_STALL]   = 1'b1;
    retire_pulse[EVT_RETIRE] = 1'b1;
`ifdef PERF_SATURATE_EN
    b_wrap_read = 16'hFFFF;
    b_next_read = 16'hFFFF;
`else
    b_wrap_read = 16'h0000;
    b_next_read = 16'h0001;
`endif

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0, 4'd0);
    bus_b.en = 1'b0; bus_b.freeze = 1'b0; bus_b.clear = 1'b0; bus_b.evt = 4'b0; bus_b.rd_sel = 4'd0;
    #3;
    checkOutput("reset_rd_data", bus_a.rd_data, 64'd0);
    checkOutput("reset_snap_data", bus_a.snap_data, 64'd0);
    checkOutput("reset_snap_valid", {63'd0, bus_a.snap_valid}, 64'd0);
    checkOutput("reset_overflow", {59'd0, bus_a.overflow}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cycle counter and first snapshot
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0, 4'd0);
    step(999);
    checkOutput("snap_valid_before_period", {63'd0, bus_a.snap_valid}, 64'd0);
    step(1);
    checkOutput("snap_valid_at_period", {63'd0, bus_a.snap_valid}, 64'd1);
    step(1);
    checkOutput("snap_valid_one_shot", {63'd0, bus_a.snap_valid}, 64'd0);
    checkOutput("snap_data_ch0", bus_a.snap_data, 64'd1000);
    checkOutput("rd_data_ch0_1001", bus_a.rd_data, 64'd1000);
    step(1);
    checkOutput("rd_data_ch0_1002", bus_a.rd_data, 64'd1001);

    // Stall events every other cycle with a freeze window in the middle
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? stall_pulse : 4'b0, 4'd2);
      step(1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, stall_pulse, 4'd2);
    step(1);
    checkOutput("freeze_ch2_first", bus_a.rd_data, 64'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0, 4'd0);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b0, stall_pulse, 4'd0);
    step(2);
    checkOutput("freeze_ch0_held", bus_a.rd_data, 64'd1012);
    checkOutput("freeze_no_snap", {63'd0, bus_a.snap_valid}, 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, stall_pulse, 4'd2);
    step(1);
    checkOutput("freeze_ch2_dropped", bus_a.rd_data, 64'd5);
    for (int i = 10; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? stall_pulse : 4'b0, 4'd2);
      step(1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0, 4'd2);
    step(1);
    checkOutput("ch2_count_10", bus_a.rd_data, 64'd10);
    checkOutput("overflow_none", {59'd0, bus_a.overflow}, 64'd0);

    // Out-of-range selects
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0, 4'd5);
    step(1);
    checkOutput("sel5_rd_data", bus_a.rd_data, 64'd0);
    checkOutput("sel5_snap_data", bus_a.snap_data, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0, 4'd15);
    step(1);
    checkOutput("sel15_rd_data", bus_a.rd_data, 64'd0);
    checkOutput("sel15_snap_data", bus_a.snap_data, 64'd0);

    // Clear on the snapshot edge suppresses the snapshot
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0, 4'd0);
    step(974);
    checkOutput("pre_clear_no_snap", {63'd0, bus_a.snap_valid}, 64'd0);
    checkOutput("pre_clear_ch0", bus_a.rd_data, 64'd1998);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0, 4'd0);
    step(1);
    checkOutput("clear_no_snap", {63'd0, bus_a.snap_valid}, 64'd0);
    checkOutput("clear_read_live", bus_a.rd_data, 64'd1999);
    applyStimulus(1'b1, 1'b0, 1'b0, retire_pulse, 4'd0);
    step(3);
    checkOutput("post_clear_ch0", bus_a.rd_data, 64'd2);
    checkOutput("post_clear_shadow_kept", bus_a.snap_data, 64'd1000);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0, 4'd1);
    step(996);
    checkOutput("post_clear_no_early_snap", {63'd0, bus_a.snap_valid}, 64'd0);
    checkOutput("post_clear_ch1", bus_a.rd_data, 64'd3);
    step(1);
    checkOutput("post_clear_snap", {63'd0, bus_a.snap_valid}, 64'd1);
    step(1);
    checkOutput("post_clear_snap_ch1", bus_a.snap_data, 64'd3);

    // Asynchronous reset mid-period
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_rd_data", bus_a.rd_data, 64'd0);
    checkOutput("async_rst_snap_data", bus_a.snap_data, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0, 4'd0);
    step(999);
    checkOutput("rst_full_period_no_snap", {63'd0, bus_a.snap_valid}, 64'd0);
    step(1);
    checkOutput("rst_full_period_snap", {63'd0, bus_a.snap_valid}, 64'd1);
    step(1);
    checkOutput("rst_snap_ch0", bus_a.snap_data, 64'd1000);

    // 16-bit wrap or saturate on the second instance
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0, 4'd0);
    bus_b.en = 1'b1;
    step(65535);
    checkOutput("b_pre_wrap_rd", {48'd0, bus_b.rd_data}, 64'hFFFE);
    checkOutput("b_pre_wrap_ovf", {59'd0, bus_b.overflow}, 64'd0);
    step(1);
    checkOutput("b_wrap_ovf", {59'd0, bus_b.overflow}, 64'd1);
    step(1);
    checkOutput("b_wrap_rd", {48'd0, bus_b.rd_data}, {48'd0, b_wrap_read});
    checkOutput("b_ovf_sticky", {59'd0, bus_b.overflow}, 64'd1);
    bus_b.en = 1'b0;
    step(1);
    checkOutput("b_after_wrap_rd", {48'd0, bus_b.rd_data}, {48'd0, b_next_read});
    bus_b.clear = 1'b1;
    step(1);
    checkOutput("b_clear_ovf", {59'd0, bus_b.overflow}, 64'd0);
    bus_b.clear = 1'b0;
    step(1);
    checkOutput("b_clear_rd", {48'd0, bus_b.rd_data}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
